// File: rtl/ctrl_completion_buffer_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_completion_buffer_pkg
//   Shared control-completion definitions: the ctrlPkt produced by every
//   execution pipe, the issue width, and the completion-buffer constants.
//   No ports (package).
// ---------------------------------------------------------------------------
package ctrl_completion_buffer_pkg;

  // Number of execution pipes, each emitting one ctrlPkt per cycle.
  localparam int ISSUE_WIDTH = 4;

  // Completion buffer sizing.
  localparam int CTRL_CB_DEPTH     = 16;
  localparam int CTRL_CB_OUT_WIDTH = 2;

  // Per-pipe completion record; valid qualifies the remaining fields.
  typedef struct packed {
    logic        valid;
    logic [6:0]  seqNo;
    logic [15:0] targetPc;
    logic        mispredict;
  } ctrlPkt;

endpackage

// File: rtl/ctrl_completion_buffer_if.sv
// ---------------------------------------------------------------------------
// ctrl_completion_buffer_if
//   Bundles the completion stream between the execution pipes, the
//   completion buffer and the active list.
//   master : pipe/recovery side (drives inputs, observes outputs)
//   slave  : completion buffer
//   Signals:
//     recoverFlag_i / exceptionFlag_i  squash requests
//     ctrlPacket_i[IN_WIDTH]           per-pipe completions
//     ctrlPacket_o[OUT_WIDTH]          completions to the active list
//     issueStall_o                     throttle to issue select
//     occupancy_o                      buffered entry count
// ---------------------------------------------------------------------------
interface ctrl_completion_buffer_if #(
  parameter int IN_WIDTH  = ctrl_completion_buffer_pkg::ISSUE_WIDTH,
  parameter int OUT_WIDTH = ctrl_completion_buffer_pkg::CTRL_CB_OUT_WIDTH,
  parameter int DEPTH     = ctrl_completion_buffer_pkg::CTRL_CB_DEPTH
) ();
  import ctrl_completion_buffer_pkg::*;

  logic                     recoverFlag_i;
  logic                     exceptionFlag_i;
  ctrlPkt [IN_WIDTH-1:0]    ctrlPacket_i;
  ctrlPkt [OUT_WIDTH-1:0]   ctrlPacket_o;
  logic                     issueStall_o;
  logic [$clog2(DEPTH):0]   occupancy_o;

  modport master (
    output recoverFlag_i, exceptionFlag_i, ctrlPacket_i,
    input  ctrlPacket_o, issueStall_o, occupancy_o
  );

  modport slave (
    input  recoverFlag_i, exceptionFlag_i, ctrlPacket_i,
    output ctrlPacket_o, issueStall_o, occupancy_o
  );

endinterface

// File: rtl/ctrl_completion_buffer_compact.sv
// ---------------------------------------------------------------------------
// ctrl_completion_buffer_compact (ctrl_compact)
//   Purely combinational packing of valid-qualified ctrlPkts into a dense
//   vector, lowest lane first, plus the number of valid inputs.
//   Ports:
//     pktIn[IN_WIDTH]     sparse per-lane packets
//     denseOut[IN_WIDTH]  packed packets, entries >= nIn are zero
//     nIn                 popcount of pktIn[*].valid
// ---------------------------------------------------------------------------
module ctrl_completion_buffer_compact
  import ctrl_completion_buffer_pkg::*;
#(
  parameter int IN_WIDTH = ISSUE_WIDTH,
  localparam int NW      = $clog2(IN_WIDTH + 1)
) (
  input  ctrlPkt [IN_WIDTH-1:0] pktIn,
  output ctrlPkt [IN_WIDTH-1:0] denseOut,
  output logic   [NW-1:0]       nIn
);

  // Running count of valid lanes seen so far selects the dense slot.
  always_comb begin
    denseOut = '0;
    nIn      = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      for (int j = 0; j < IN_WIDTH; j++) begin
        denseOut[j] = (pktIn[i].valid && (nIn == NW'(j))) ? pktIn[i] : denseOut[j];
      end
      nIn = nIn + (pktIn[i].valid ? NW'(1) : NW'(0));
    end
  end

endmodule

// File: rtl/ctrl_completion_buffer.sv
// ---------------------------------------------------------------------------
// ctrl_completion_buffer
//   Collects completions from IN_WIDTH execution pipes into an in-order FIFO
//   and drains up to OUT_WIDTH per cycle to the active list. Because the
//   pipes cannot stall, issue is throttled once occupancy reaches
//   STALL_THRESH. Recovery/exception squash the whole buffer.
//   Ports:
//     clk    core clock
//     reset  synchronous, active-high
//     cb     ctrl_completion_buffer_if.slave (flags, ctrlPacket_i/o,
//            issueStall_o, occupancy_o)
// ---------------------------------------------------------------------------
module ctrl_completion_buffer
  import ctrl_completion_buffer_pkg::*;
#(
  parameter int IN_WIDTH     = ISSUE_WIDTH,
  parameter int OUT_WIDTH    = CTRL_CB_OUT_WIDTH,
  parameter int DEPTH        = CTRL_CB_DEPTH,
  parameter int STALL_THRESH = DEPTH - 4 * IN_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  ctrl_completion_buffer_if.slave cb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(IN_WIDTH + 1);

  ctrlPkt                 memR [DEPTH];
  logic   [PW-1:0]        headR;
  logic   [PW-1:0]        tailR;
  logic   [CW-1:0]        countR;
  ctrlPkt [OUT_WIDTH-1:0] outR;
  logic                   stallR;

  ctrlPkt [IN_WIDTH-1:0]  denseS;
  logic   [NW-1:0]        nInS;
  logic                   squashS;
  logic                   overflowS;
  logic   [CW-1:0]        availS;
  logic   [CW-1:0]        nOutFullS;
  logic   [CW-1:0]        acceptS;
  logic   [CW-1:0]        availAccS;
  logic   [CW-1:0]        nOutS;
  logic   [CW-1:0]        countNextS;
  logic   [CW-1:0]        offS;
  ctrlPkt [OUT_WIDTH-1:0] outNextS;

  ctrl_completion_buffer_compact #(.IN_WIDTH(IN_WIDTH)) uCompact (
    .pktIn    (cb.ctrlPacket_i),
    .denseOut (denseS),
    .nIn      (nInS)
  );

  // Enqueue/dequeue bookkeeping. The drain candidates are the stored
  // entries (oldest first) followed by this cycle's compacted inputs, so an
  // empty buffer forwards inputs to the output register in one cycle.
  // A cycle whose inputs would not fit is dropped as a whole.
  always_comb begin
    squashS    = cb.recoverFlag_i | cb.exceptionFlag_i;
    availS     = countR + CW'(nInS);
    nOutFullS  = (availS < CW'(OUT_WIDTH)) ? availS : CW'(OUT_WIDTH);
    overflowS  = (availS - nOutFullS) > CW'(DEPTH);
    acceptS    = overflowS ? '0 : CW'(nInS);
    availAccS  = countR + acceptS;
    nOutS      = (availAccS < CW'(OUT_WIDTH)) ? availAccS : CW'(OUT_WIDTH);
    countNextS = availAccS - nOutS;
  end

  // Select the next output lanes: stored entries first, then dense inputs.
  always_comb begin
    outNextS = '0;
    offS     = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      offS = CW'(k) - countR;
      if (CW'(k) >= nOutS) begin
        outNextS[k] = '0;
      end else if (CW'(k) < countR) begin
        outNextS[k] = memR[headR + PW'(k)];
      end else begin
        for (int i = 0; i < IN_WIDTH; i++) begin
          outNextS[k] = (offS == CW'(i)) ? denseS[i] : outNextS[k];
        end
      end
    end
  end

  // Storage write; slots past a dequeued head may be rewritten in the same
  // cycle because the read above uses the pre-edge contents.
  always_ff @(posedge clk) begin
    if (!reset && !squashS) begin
      for (int j = 0; j < IN_WIDTH; j++) begin
        if (CW'(j) < acceptS) begin
          memR[tailR + PW'(j)] <= denseS[j];
        end
      end
    end
  end

  // Pointers, count, output and stall registers; reset beats squash.
  always_ff @(posedge clk) begin
    if (reset || squashS) begin
      headR  <= '0;
      tailR  <= '0;
      countR <= '0;
      outR   <= '0;
      stallR <= 1'b0;
    end else begin
      headR  <= headR + PW'(nOutS);
      tailR  <= tailR + PW'(acceptS);
      countR <= countNextS;
      outR   <= outNextS;
      stallR <= (int'(countNextS) >= STALL_THRESH);
    end
  end

  assign cb.ctrlPacket_o = outR;
  assign cb.issueStall_o = stallR;
  assign cb.occupancy_o  = countR;

  // Issue throttling must keep the buffer from ever being overrun.
  assert property (@(posedge clk) disable iff (reset) !(overflowS && !squashS))
    else $error("ctrl_completion_buffer: overrun, inputs dropped");

endmodule

// File: tb/tb_ctrl_completion_buffer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_completion_buffer
//   Directed bench: instance A uses default sizing (DEPTH 16, threshold 0),
//   instance B uses DEPTH 32 with threshold 16. Both see the same inputs.
// ---------------------------------------------------------------------------
module tb_ctrl_completion_buffer;
  import ctrl_completion_buffer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic                     recover;
  logic                     exception;
  ctrlPkt [ISSUE_WIDTH-1:0] pktIn;

  int checks   = 0;
  int failures = 0;
  int modelQ[$];
  int nextId;

  ctrl_completion_buffer_if ifA ();
  ctrl_completion_buffer_if #(.DEPTH(32)) ifB ();

  assign ifA.recoverFlag_i   = recover;
  assign ifA.exceptionFlag_i = exception;
  assign ifA.ctrlPacket_i    = pktIn;
  assign ifB.recoverFlag_i   = recover;
  assign ifB.exceptionFlag_i = exception;
  assign ifB.ctrlPacket_i    = pktIn;

  ctrl_completion_buffer dutA (.clk(clk), .reset(reset), .cb(ifA));
  ctrl_completion_buffer #(.DEPTH(32), .STALL_THRESH(16)) dutB (.clk(clk), .reset(reset), .cb(ifB));

  function automatic ctrlPkt mk(input int id);
    ctrlPkt p;
    p          = '0;
    p.valid    = 1'b1;
    p.seqNo    = 7'(id);
    p.targetPc = 16'(id * 3);
    return p;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of instance A against the FIFO model: the oldest min(n,2)
  // ids must appear in order on lanes 0..1.
  task automatic modelCycle(input string tag);
    int n;
    step();
    n = (modelQ.size() < 2) ? modelQ.size() : 2;
    for (int k = 0; k < 2; k++) begin
      checkVal({tag, "_v"}, 32'(ifA.ctrlPacket_o[k].valid), 32'(k < n));
      if (k < n) checkVal({tag, "_id"}, 32'(ifA.ctrlPacket_o[k].seqNo), 32'(modelQ[k]));
    end
    for (int k = 0; k < n; k++) void'(modelQ.pop_front());
    checkVal({tag, "_occ"}, 32'(ifA.occupancy_o), 32'(modelQ.size()));
  endtask

  initial begin
    reset = 1'b1; recover = 1'b0; exception = 1'b0; pktIn = '0;
    repeat (2) step();
    checkVal("rst_a_v0",  32'(ifA.ctrlPacket_o[0].valid), 32'd0);
    checkVal("rst_a_v1",  32'(ifA.ctrlPacket_o[1].valid), 32'd0);
    checkVal("rst_a_occ", 32'(ifA.occupancy_o), 32'd0);
    checkVal("rst_a_stl", 32'(ifA.issueStall_o), 32'd0);
    checkVal("rst_b_stl", 32'(ifB.issueStall_o), 32'd0);

    // Lanes 0 and 2 valid: A then B on output lanes 0,1 one cycle later.
    reset = 1'b0;
    pktIn[0] = mk(10); pktIn[2] = mk(11);
    step();
    pktIn = '0;
    checkVal("t1_v0",  32'(ifA.ctrlPacket_o[0].valid), 32'd1);
    checkVal("t1_id0", 32'(ifA.ctrlPacket_o[0].seqNo), 32'd10);
    checkVal("t1_pc0", 32'(ifA.ctrlPacket_o[0].targetPc), 32'd30);
    checkVal("t1_v1",  32'(ifA.ctrlPacket_o[1].valid), 32'd1);
    checkVal("t1_id1", 32'(ifA.ctrlPacket_o[1].seqNo), 32'd11);
    checkVal("t1_occ", 32'(ifA.occupancy_o), 32'd0);
    checkVal("t1_stlb", 32'(ifB.issueStall_o), 32'd0);
    step();
    checkVal("t1_idle_v0", 32'(ifA.ctrlPacket_o[0].valid), 32'd0);

    // 8 bursts of 4: occupancy grows by 2, B stalls once it reaches 16.
    for (int b = 0; b < 8; b++) begin
      for (int l = 0; l < 4; l++) pktIn[l] = mk(20 + 4 * b + l);
      step();
      checkVal("t3_occa", 32'(ifA.occupancy_o), 32'(2 * (b + 1)));
      checkVal("t3_occb", 32'(ifB.occupancy_o), 32'(2 * (b + 1)));
      checkVal("t2_stla", 32'(ifA.issueStall_o), 32'd1);
      checkVal("t3_stlb", 32'(ifB.issueStall_o), 32'(b == 7));
      checkVal("t3_id0",  32'(ifA.ctrlPacket_o[0].seqNo), 32'(20 + 2 * b));
      checkVal("t3_id1",  32'(ifB.ctrlPacket_o[1].seqNo), 32'(21 + 2 * b));
    end
    pktIn = '0;
    for (int d = 0; d < 8; d++) begin
      step();
      checkVal("t3_drn_occb", 32'(ifB.occupancy_o), 32'(14 - 2 * d));
      checkVal("t3_drn_stlb", 32'(ifB.issueStall_o), 32'd0);
      checkVal("t3_drn_id0",  32'(ifB.ctrlPacket_o[0].seqNo), 32'(36 + 2 * d));
      checkVal("t3_drn_id1",  32'(ifA.ctrlPacket_o[1].seqNo), 32'(37 + 2 * d));
    end
    step();
    checkVal("t3_empty_v0", 32'(ifA.ctrlPacket_o[0].valid), 32'd0);
    checkVal("t3_empty_occ", 32'(ifA.occupancy_o), 32'd0);

    // Wrap: 3 inputs on lanes 0,1,3 every other cycle for 40 cycles.
    modelQ.delete();
    nextId = 60;
    for (int c = 0; c < 40; c++) begin
      pktIn = '0;
      if (c % 2 == 0) begin
        pktIn[0] = mk(nextId); pktIn[1] = mk(nextId + 1); pktIn[3] = mk(nextId + 2);
        for (int i = 0; i < 3; i++) modelQ.push_back(nextId + i);
        nextId += 3;
      end
      modelCycle("wrap");
    end
    pktIn = '0;
    repeat (3) modelCycle("wrap_drain");
    checkVal("wrap_left", 32'(modelQ.size()), 32'd0);

    // Recover with 10 queued and 4 new inputs: everything is discarded.
    for (int b = 0; b < 5; b++) begin
      for (int l = 0; l < 4; l++) pktIn[l] = mk(4 * b + l);
      step();
    end
    checkVal("t5_occ10", 32'(ifA.occupancy_o), 32'd10);
    recover = 1'b1;
    for (int l = 0; l < 4; l++) pktIn[l] = mk(100 + l);
    step();
    recover = 1'b0; pktIn = '0;
    checkVal("t5_v0",  32'(ifA.ctrlPacket_o[0].valid), 32'd0);
    checkVal("t5_v1",  32'(ifA.ctrlPacket_o[1].valid), 32'd0);
    checkVal("t5_occ", 32'(ifA.occupancy_o), 32'd0);
    checkVal("t5_stl", 32'(ifA.issueStall_o), 32'd0);
    step();
    checkVal("t5_after_v0",  32'(ifA.ctrlPacket_o[0].valid), 32'd0);
    checkVal("t5_after_occ", 32'(ifA.occupancy_o), 32'd0);

    // Exception squash, then an input in the very next cycle is accepted.
    for (int l = 0; l < 4; l++) pktIn[l] = mk(40 + l);
    step();
    exception = 1'b1; pktIn = '0; pktIn[0] = mk(44);
    step();
    exception = 1'b0; pktIn = '0; pktIn[3] = mk(50);
    checkVal("exc_v0",  32'(ifA.ctrlPacket_o[0].valid), 32'd0);
    checkVal("exc_occ", 32'(ifA.occupancy_o), 32'd0);
    step();
    pktIn = '0;
    checkVal("exc_next_id0", 32'(ifA.ctrlPacket_o[0].seqNo), 32'd50);
    checkVal("exc_next_v0",  32'(ifA.ctrlPacket_o[0].valid), 32'd1);
    checkVal("exc_next_v1",  32'(ifA.ctrlPacket_o[1].valid), 32'd0);

    // Reset mid-drain with 6 entries queued.
    for (int b = 0; b < 3; b++) begin
      for (int l = 0; l < 4; l++) pktIn[l] = mk(60 + 4 * b + l);
      step();
    end
    pktIn = '0;
    checkVal("t6_occ6", 32'(ifA.occupancy_o), 32'd6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkVal("t6_v0",  32'(ifA.ctrlPacket_o[0].valid), 32'd0);
    checkVal("t6_v1",  32'(ifA.ctrlPacket_o[1].valid), 32'd0);
    checkVal("t6_occ", 32'(ifA.occupancy_o), 32'd0);
    pktIn[1] = mk(77);
    step();
    pktIn = '0;
    checkVal("t6_x_v0",  32'(ifA.ctrlPacket_o[0].valid), 32'd1);
    checkVal("t6_x_id0", 32'(ifA.ctrlPacket_o[0].seqNo), 32'd77);
    checkVal("t6_x_v1",  32'(ifA.ctrlPacket_o[1].valid), 32'd0);
    checkVal("t6_x_occ", 32'(ifA.occupancy_o), 32'd0);
    step();
    checkVal("t6_end_v0", 32'(ifA.ctrlPacket_o[0].valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
